// File: rtl/mant_div24.sv
// mant_div24: sequential restoring mantissa divider, 48-bit dividend by
// 24-bit divisor, one quotient bit per clock. Produces a 24-bit quotient and
// a 24-bit remainder, and flags overflow and divide-by-zero. The
// overflow/divide-by-zero cases return a saturated result after one cycle.
// Optional feature: define MANT_DIV24_STICKY_EN to add the registered sticky
// output (remainder non-zero).
module mant_div24 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] dividend,
    input  logic [23:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] quotient,
    output logic [23:0] remainder,
    output logic        ovf,
    output logic        dbz
`ifdef MANT_DIV24_STICKY_EN
    ,
    output logic        sticky
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_r;
    logic [23:0] divisor_r;
    logic [23:0] rem_r;        // partial remainder, always < divisor_r
    logic [23:0] shreg_r;      // low dividend bits still to be consumed, MSB first
    logic [23:0] q_r;          // quotient bits collected so far
    logic [4:0]  count_r;
    logic        fast_r;       // operands give a saturated result, skip iterations
    logic        dbz_pend_r;

    logic        in_ready_r;
    logic        out_valid_r;
    logic [23:0] quotient_r;
    logic [23:0] remainder_r;
    logic        ovf_r;
    logic        dbz_r;
`ifdef MANT_DIV24_STICKY_EN
    logic        sticky_r;
`endif

    logic [24:0] t_s;
    logic        ge_s;
    logic [23:0] rem_step_s;
    logic [23:0] q_step_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // t - divisor < divisor < 2^24, so the low 24 bits of the difference are exact.
    always_comb begin
        t_s = {rem_r, shreg_r[23]};
        if (t_s >= {1'b0, divisor_r}) begin
            ge_s       = 1'b1;
            rem_step_s = t_s[23:0] - divisor_r;
        end else begin
            ge_s       = 1'b0;
            rem_step_s = t_s[23:0];
        end
        q_step_s = {q_r[22:0], ge_s};
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            divisor_r   <= 24'd0;
            rem_r       <= 24'd0;
            shreg_r     <= 24'd0;
            q_r         <= 24'd0;
            count_r     <= 5'd0;
            fast_r      <= 1'b0;
            dbz_pend_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= 24'd0;
            remainder_r <= 24'd0;
            ovf_r       <= 1'b0;
            dbz_r       <= 1'b0;
`ifdef MANT_DIV24_STICKY_EN
            sticky_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_r <= 1'b0;
                        divisor_r  <= divisor;
                        rem_r      <= dividend[47:24];
                        shreg_r    <= dividend[23:0];
                        q_r        <= 24'd0;
                        count_r    <= 5'd23;
                        // A zero divisor also satisfies hi >= divisor.
                        fast_r     <= (dividend[47:24] >= divisor);
                        dbz_pend_r <= (divisor == 24'd0);
                        state_r    <= RUN;
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                RUN: begin
                    if (fast_r) begin
                        quotient_r  <= 24'hFFFFFF;
                        remainder_r <= 24'd0;
                        ovf_r       <= 1'b1;
                        dbz_r       <= dbz_pend_r;
`ifdef MANT_DIV24_STICKY_EN
                        sticky_r    <= 1'b0;
`endif
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        rem_r   <= rem_step_s;
                        shreg_r <= {shreg_r[22:0], 1'b0};
                        q_r     <= q_step_s;
                        if (count_r == 5'd0) begin
                            quotient_r  <= q_step_s;
                            remainder_r <= rem_step_s;
                            ovf_r       <= 1'b0;
                            dbz_r       <= 1'b0;
`ifdef MANT_DIV24_STICKY_EN
                            sticky_r    <= |rem_step_s;
`endif
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            count_r <= count_r - 5'd1;
                            state_r <= RUN;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign ovf       = ovf_r;
    assign dbz       = dbz_r;
`ifdef MANT_DIV24_STICKY_EN
    assign sticky    = sticky_r;
`endif

endmodule

// File: tb/tb_mant_div24.sv
// tb_mant_div24: table-driven and randomized bench for mant_div24, with a
// plain-arithmetic reference model (integer division of the full operands).
module tb_mant_div24;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] dividend;
    logic [23:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] quotient;
    logic [23:0] remainder;
    logic        ovf;
    logic        dbz;
`ifdef MANT_DIV24_STICKY_EN
    logic        sticky;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    mant_div24 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
`ifdef MANT_DIV24_STICKY_EN
        ,
        .sticky    (sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] dd;
        logic [23:0] dv;
        logic [23:0] q;
        logic [23:0] r;
        logic        o;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-width integer division; overflow when the quotient needs >24 bits.
    task automatic model(input logic [47:0] dd, input logic [23:0] dv,
                         output logic [23:0] q, output logic [23:0] r,
                         output logic o, output logic z);
        logic [47:0] qq;
        logic [47:0] rr;
        if (dv == 24'd0) begin
            q = 24'hFFFFFF; r = 24'd0; o = 1'b1; z = 1'b1;
        end else begin
            qq = dd / {24'd0, dv};
            rr = dd % {24'd0, dv};
            if (qq >= 48'h000001_000000) begin
                q = 24'hFFFFFF; r = 24'd0; o = 1'b1; z = 1'b0;
            end else begin
                q = qq[23:0]; r = rr[23:0]; o = 1'b0; z = 1'b0;
            end
        end
    endtask

    task automatic do_accept(input logic [47:0] dd, input logic [23:0] dv);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_before_accept", {47'd0, in_ready}, 48'd1);
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input logic [23:0] q, input logic [23:0] r,
                                input logic o, input logic z);
        chk({tag, "_latency"}, 48'(lat), 48'(exp_lat));
        chk({tag, "_quotient"}, {24'd0, quotient}, {24'd0, q});
        chk({tag, "_remainder"}, {24'd0, remainder}, {24'd0, r});
        chk({tag, "_ovf"}, {47'd0, ovf}, {47'd0, o});
        chk({tag, "_dbz"}, {47'd0, dbz}, {47'd0, z});
`ifdef MANT_DIV24_STICKY_EN
        chk({tag, "_sticky"}, {47'd0, sticky}, {47'd0, (!o && r != 24'd0)});
`endif
    endtask

    initial begin
        logic [47:0] prod;
        logic [47:0] dd;
        logic [23:0] dv;
        logic [23:0] eq;
        logic [23:0] er;
        logic        eo;
        logic        ez;
        logic [23:0] hi;
        int          lat;

        prod = 48'hABCDEF * 48'h123456;
        vecs[0] = '{48'h600000_000000, 24'h800000, 24'hC00000, 24'h000000, 1'b0, 1'b0, 24};
        vecs[1] = '{48'h000000_000007, 24'h000003, 24'h000002, 24'h000001, 1'b0, 1'b0, 24};
        vecs[2] = '{48'h123456_789ABC, 24'h000000, 24'hFFFFFF, 24'h000000, 1'b1, 1'b1, 1};
        vecs[3] = '{48'h800000_000000, 24'h800000, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1};
        vecs[4] = '{prod,              24'hABCDEF, 24'h123456, 24'h000000, 1'b0, 1'b0, 24};
        vecs[5] = '{48'hFFFFFE_FFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b0, 1'b0, 24};
        vecs[6] = '{48'h000005_000000, 24'h000005, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1};
        vecs[7] = '{48'h000000_000001, 24'h000001, 24'h000001, 24'h000000, 1'b0, 1'b0, 24};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 48'd0;
        divisor   = 24'd0;
        #12;
        chk("reset_in_ready", {47'd0, in_ready}, 48'd1);
        chk("reset_out_valid", {47'd0, out_valid}, 48'd0);
        chk("reset_quotient", {24'd0, quotient}, 48'd0);
        chk("reset_remainder", {24'd0, remainder}, 48'd0);
        chk("reset_flags", {46'd0, ovf, dbz}, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_accept(vecs[i].dd, vecs[i].dv);
            wait_result(lat);
            check_result($sformatf("vec%0d", i), lat, vecs[i].lat,
                         vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].z);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid_drop", i), {47'd0, out_valid}, 48'd0);
            chk($sformatf("vec%0d_ready_back", i), {47'd0, in_ready}, 48'd1);
        end

        // Backpressure: result must hold and new operands must be ignored
        out_ready = 1'b0;
        do_accept(48'h600000_000000, 24'h800000);
        wait_result(lat);
        chk("bp_latency", 48'(lat), 48'd24);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dividend = {$urandom(), $urandom()};
            divisor  = 24'($urandom());
            @(posedge clk); #1;
            chk("bp_out_valid", {47'd0, out_valid}, 48'd1);
            chk("bp_in_ready", {47'd0, in_ready}, 48'd0);
            chk("bp_quotient", {24'd0, quotient}, 48'h000000_C00000);
            chk("bp_remainder", {24'd0, remainder}, 48'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {47'd0, out_valid}, 48'd0);
        chk("bp_release_ready", {47'd0, in_ready}, 48'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_no_ghost_result", {46'd0, out_valid, in_ready}, 48'd1);
        end

        // Mid-run reset: leave a non-zero result on the outputs first
        do_accept(48'h000000_000007, 24'h000003);
        wait_result(lat);
        chk("pre_rst_quotient", {24'd0, quotient}, 48'd2);
        @(posedge clk); #1;
        do_accept(48'h600000_000000, 24'h800000);
        for (int i = 1; i < 12; i++) begin
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {47'd0, in_ready}, 48'd1);
        chk("rst_out_valid", {47'd0, out_valid}, 48'd0);
        chk("rst_quotient", {24'd0, quotient}, 48'd0);
        chk("rst_remainder", {24'd0, remainder}, 48'd0);
        chk("rst_flags", {46'd0, ovf, dbz}, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_accept(48'h000000_00000A, 24'h000005);
        wait_result(lat);
        check_result("post_rst", lat, 24, 24'd2, 24'd0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Randomized against the reference model
        for (int i = 0; i < 150; i++) begin
            if (i % 16 == 3) begin
                dv = 24'($urandom_range(0, 7));
            end else begin
                dv = 24'($urandom());
            end
            if (i % 5 == 0 || dv == 24'd0) begin
                hi = 24'($urandom());
            end else begin
                hi = 24'($urandom() % {8'd0, dv});
            end
            dd = {hi, 24'($urandom())};
            model(dd, dv, eq, er, eo, ez);
            do_accept(dd, dv);
            wait_result(lat);
            check_result($sformatf("rnd%0d", i), lat, eo ? 1 : 24, eq, er, eo, ez);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
